// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: DMType codes, MMIO register offsets and the alignment rule shared by the data-memory responder.
package dmem_responder_pkg;
  localparam logic [2:0] dm_word              = 3'b000;
  localparam logic [2:0] dm_halfword          = 3'b001;
  localparam logic [2:0] dm_halfword_unsigned = 3'b010;
  localparam logic [2:0] dm_byte              = 3'b011;
  localparam logic [2:0] dm_byte_unsigned     = 3'b100;
  localparam logic [3:0] MMIO_CYCLE  = 4'h0;
  localparam logic [3:0] MMIO_CMP    = 4'h4;
  localparam logic [3:0] MMIO_STATUS = 4'h8;
  localparam logic [3:0] MMIO_STCNT  = 4'hC;
  // Undefined access types count as misaligned so they can never write.
  function automatic logic dm_misaligned(input logic [2:0] t, input logic [1:0] off);
    return t == dm_word ? |off :
           (t == dm_halfword || t == dm_halfword_unsigned) ? off[0] :
           (t == dm_byte || t == dm_byte_unsigned) ? 1'b0 : 1'b1;
  endfunction
endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: combinational byte/halfword store-merge and load-extract/extend for one 32-bit word.
module dmem_lane
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  i_dmtype,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_wr_word,
  output logic [31:0] o_rd_data,
  output logic        o_misalign
);
  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_bsh  = {i_off, 3'b000};
  assign w_hsh  = {i_off[1], 4'b0000};
  assign w_byte = 8'(i_old >> w_bsh);
  assign w_half = 16'(i_old >> w_hsh);
  assign o_misalign = dm_misaligned(i_dmtype, i_off);
  always_comb begin
    o_rd_data = i_dmtype == dm_word              ? i_old :
                i_dmtype == dm_halfword          ? {{16{w_half[15]}}, w_half} :
                i_dmtype == dm_halfword_unsigned ? {16'b0, w_half} :
                i_dmtype == dm_byte              ? {{24{w_byte[7]}}, w_byte} :
                i_dmtype == dm_byte_unsigned     ? {24'b0, w_byte} : 32'b0;
    o_wr_word = i_dmtype == dm_word ? i_wdata :
                (i_dmtype == dm_halfword || i_dmtype == dm_halfword_unsigned) ?
                  (i_old & ~(32'h0000_FFFF << w_hsh)) | ({16'b0, i_wdata[15:0]} << w_hsh) :
                (i_dmtype == dm_byte || i_dmtype == dm_byte_unsigned) ?
                  (i_old & ~(32'h0000_00FF << w_bsh)) | ({24'b0, i_wdata[7:0]} << w_bsh) :
                i_old;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-side RAM with lane handling plus an MMIO window (cycle counter, timer compare, status, store count).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           MemWrite,
  input  logic [31:0]                    Addr_in,
  input  logic [31:0]                    Data_in,
  input  logic [2:0]                     DMType,
  output logic [31:0]                    Data_out,
  output logic                           misalign_err,
  output logic                           irq_timer,
  input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr,
  output logic [31:0]                    dbg_data
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0]   r_ram [DEPTH_WORDS];
  logic [31:0]   r_cycle;
  logic [31:0]   r_cmp;
  logic [1:0]    r_status;
  logic [31:0]   r_stcnt;
  logic          w_mmio;
  logic [31:0]   w_moff;
  logic          w_reg;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_old;
  logic [31:0]   w_wr;
  logic [31:0]   w_lane_rd;
  logic          w_lane_mis;
  logic          w_mis;
  logic          w_we;
  logic          w_w1c;
  logic          w_tset;
  logic [31:0]   w_mmio_rd;
  assign w_mmio = Addr_in >= MMIO_BASE;
  assign w_moff = Addr_in - MMIO_BASE;
  assign w_reg  = w_moff[31:4] == '0;
  assign w_idx  = Addr_in[AW+1:2];
  assign w_old  = r_ram[w_idx];
  dmem_lane u_lane (
    .i_dmtype  (DMType),
    .i_off     (Addr_in[1:0]),
    .i_old     (w_old),
    .i_wdata   (Data_in),
    .o_wr_word (w_wr),
    .o_rd_data (w_lane_rd),
    .o_misalign(w_lane_mis)
  );
  // MMIO only accepts whole-word accesses; anything narrower faults like a misalignment.
  assign w_mis  = w_lane_mis | (w_mmio & (DMType != dm_word));
  assign w_we   = MemWrite & ~w_mis;
  assign w_w1c  = w_we & w_mmio & w_reg & (w_moff[3:0] == MMIO_STATUS);
  assign w_tset = (r_cmp != 32'd0) & (r_cycle == r_cmp);
  always_comb begin
    w_mmio_rd = !w_reg ? 32'd0 :
                w_moff[3:0] == MMIO_CYCLE  ? r_cycle :
                w_moff[3:0] == MMIO_CMP    ? r_cmp :
                w_moff[3:0] == MMIO_STATUS ? {30'b0, r_status} :
                w_moff[3:0] == MMIO_STCNT  ? r_stcnt : 32'd0;
    Data_out  = w_mis ? 32'd0 : w_mmio ? w_mmio_rd : w_lane_rd;
  end
  assign misalign_err = w_mis;
  assign irq_timer    = r_status[0];
  assign dbg_data     = r_ram[dbg_addr];
  always_ff @(posedge clk)
    if (!reset && w_we && !w_mmio) r_ram[w_idx] <= w_wr;
  // Set conditions win over a same-cycle write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle  <= '0;
      r_cmp    <= '0;
      r_status <= '0;
      r_stcnt  <= '0;
    end else begin
      r_cycle     <= r_cycle + 32'd1;
      r_status[0] <= w_tset | (r_status[0] & ~(w_w1c & Data_in[0]));
      r_status[1] <= w_mis | (r_status[1] & ~(w_w1c & Data_in[1]));
      if (w_we) r_stcnt <= r_stcnt + 32'd1;
      if (w_we && w_mmio && w_reg && w_moff[3:0] == MMIO_CMP) r_cmp <= Data_in;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: random and directed stimulus checked every cycle against a behavioural memory/MMIO model.
module tb_dmem_responder;
  localparam int          DW   = 1024;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
  logic        clk = 0, reset = 1, MemWrite = 0;
  logic [31:0] Addr_in = BASE + 32'h10, Data_in = 0;
  logic [2:0]  DMType = 0;
  logic [9:0]  dbg_addr = 0;
  logic [31:0] Data_out, dbg_data;
  logic        misalign_err, irq_timer;
  dmem_responder dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Addr_in(Addr_in), .Data_in(Data_in),
    .DMType(DMType), .Data_out(Data_out), .misalign_err(misalign_err), .irq_timer(irq_timer),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  always #5 clk = ~clk;
  bit [31:0] m_mem [DW];
  bit        m_known [DW];
  bit [31:0] m_cycle, m_cmp, m_stcnt;
  bit [1:0]  m_status;
  int        n_pass = 0, n_total = 0;
  logic [31:0] s_q, s_dbg;
  logic        s_e, s_irq;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction
  function automatic bit m_mis(bit [31:0] a, bit [2:0] t);
    if (t > 4) return 1;
    if (a >= BASE && t != 0) return 1;
    if (t == 0) return a % 4 != 0;
    if (t <= 2) return a % 2 != 0;
    return 0;
  endfunction
  function automatic bit [31:0] m_out(bit [31:0] a, bit [2:0] t);
    bit [31:0] w, v, off;
    off = a - BASE;
    if (m_mis(a, t)) return 0;
    if (a >= BASE)
      return off == 0 ? m_cycle : off == 4 ? m_cmp : off == 8 ? {30'b0, m_status} : off == 12 ? m_stcnt : 0;
    w = m_mem[(a / 4) % DW];
    if (t == 0) return w;
    if (t <= 2) begin
      v = (w >> (8 * (a % 4 / 2 * 2))) & 32'hFFFF;
      return (t == 1 && v >= 32'h8000) ? v | 32'hFFFF_0000 : v;
    end
    v = (w >> (8 * (a % 4))) & 32'hFF;
    return (t == 3 && v >= 32'h80) ? v | 32'hFFFF_FF00 : v;
  endfunction
  task automatic step(input bit we, input bit [31:0] a, input bit [31:0] d, input bit [2:0] t, input bit rst);
    bit mis, mmio, set0, ok, w1c;
    bit [31:0] off, sh;
    int idx;
    MemWrite = we; Addr_in = a; Data_in = d; DMType = t; reset = rst;
    mis = m_mis(a, t); mmio = a >= BASE; off = a - BASE; idx = (a / 4) % DW;
    @(negedge clk);
    s_q = Data_out; s_e = misalign_err; s_irq = irq_timer; s_dbg = dbg_data;
    chk("misalign_err", s_e, mis);
    chk("irq_timer", s_irq, m_status[0]);
    if (mis || mmio || m_known[idx]) chk("Data_out", s_q, m_out(a, t));
    if (m_known[dbg_addr]) chk("dbg_data", s_dbg, m_mem[dbg_addr]);
    @(posedge clk);
    if (rst) begin
      m_cycle = 0; m_cmp = 0; m_status = 0; m_stcnt = 0;
    end else begin
      set0 = m_cmp != 0 && m_cycle == m_cmp;
      ok   = we && !mis;
      w1c  = ok && mmio && off == 8;
      m_status[0] = set0 | (m_status[0] & !(w1c & d[0]));
      m_status[1] = mis | (m_status[1] & !(w1c & d[1]));
      if (ok) begin
        m_stcnt++;
        if (mmio) begin
          if (off == 4) m_cmp = d;
        end else begin
          if (t == 0) m_mem[idx] = d;
          else if (t <= 2) begin
            sh = 8 * (a % 4 / 2 * 2);
            m_mem[idx] = (m_mem[idx] & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
          end else begin
            sh = 8 * (a % 4);
            m_mem[idx] = (m_mem[idx] & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
          end
          m_known[idx] = 1;
        end
      end
      m_cycle++;
    end
    #1;
  endtask
  initial begin
    int k;
    bit [31:0] a, d, s0;
    bit [2:0]  t;
    @(posedge clk); #1;
    for (int i = 0; i < DW; i++) begin
      dbg_addr = 10'(i);
      step(1, 32'(i * 4), $urandom, 0, 0);
    end
    // timer: compare at 20 with a same-cycle W1C that must lose
    step(0, BASE + 32'h10, 0, 0, 1);
    step(1, BASE + 4, 20, 0, 0);
    k = 0;
    do begin step(0, BASE, 0, 0, 0); k++; end while (s_q != 19 && k < 50);
    chk("timer_wait_cycle19", s_q, 19);
    step(1, BASE + 8, 1, 0, 0);
    step(0, BASE + 8, 0, 0, 0);
    chk("status_after_set", s_q, 1);
    chk("irq_after_set", s_irq, 1);
    step(1, BASE + 8, 1, 0, 0);
    step(0, BASE + 8, 0, 0, 0);
    chk("status_after_w1c", s_q, 0);
    chk("irq_after_w1c", s_irq, 0);
    // lane extraction and half merge
    dbg_addr = 4;
    step(1, 32'h10, 32'h8765_4321, 0, 0);
    step(0, 32'h11, 0, 3, 0); chk("lb_0x11", s_q, 32'h0000_0043);
    step(0, 32'h13, 0, 3, 0); chk("lb_0x13", s_q, 32'hFFFF_FF87);
    step(0, 32'h13, 0, 4, 0); chk("lbu_0x13", s_q, 32'h0000_0087);
    step(1, 32'h12, 32'h1234_BEEF, 1, 0);
    step(0, 32'h12, 0, 1, 0); chk("lh_0x12", s_q, 32'hFFFF_BEEF); chk("dbg_half_merge", s_dbg, 32'hBEEF_4321);
    step(0, 32'h12, 0, 2, 0); chk("lhu_0x12", s_q, 32'h0000_BEEF);
    // misaligned store
    step(0, BASE + 12, 0, 0, 0); s0 = s_q;
    step(1, 32'h21, 32'h1111_1111, 0, 0); chk("mis_err", s_e, 1); chk("mis_data", s_q, 0);
    step(0, BASE + 8, 0, 0, 0); chk("status_mis", s_q, 2);
    step(1, BASE + 8, 2, 0, 0);
    step(0, BASE + 8, 0, 0, 0); chk("status_mis_clr", s_q, 0);
    step(0, BASE + 12, 0, 0, 0); chk("stcnt_skip_fault", s_q, s0 + 1);
    // alias wrap with read-before-write
    dbg_addr = 1;
    step(1, 32'h4, 32'h1234_5678, 0, 0);
    step(1, 32'h4 + DW * 4, 32'hA5, 3, 0); chk("alias_old_byte", s_q, 32'h78);
    step(0, 32'h4, 0, 0, 0); chk("alias_dbg", s_dbg, 32'h1234_56A5);
    // reset wins over a concurrent store
    dbg_addr = 16;
    step(0, BASE + 32'h10, 0, 0, 1);
    step(1, 32'h40, 32'hCAFE_F00D, 0, 0);
    step(1, BASE + 4, 100, 0, 0);
    step(0, 32'h41, 0, 0, 0);
    k = 0;
    do begin step(0, BASE, 0, 0, 0); k++; end while (s_q != 56 && k < 80);
    chk("rst_wait_cycle56", s_q, 56);
    step(1, 32'h40, 32'hDEAD_BEEF, 0, 1);
    step(0, BASE, 0, 0, 0);      chk("rst_cycle", s_q, 0); chk("rst_irq", s_irq, 0);
    step(0, BASE + 4, 0, 0, 0);  chk("rst_cmp", s_q, 0);
    step(0, BASE + 8, 0, 0, 0);  chk("rst_status", s_q, 0);
    step(0, BASE + 12, 0, 0, 0); chk("rst_stcnt", s_q, 0); chk("rst_ram_kept", s_dbg, 32'hCAFE_F00D);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      t = ($urandom % 10 == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      if ($urandom % 10 < 7) a = $urandom_range(0, 32'h3FFF);
      else begin
        a = BASE + $urandom_range(0, 31);
        if ($urandom % 4 != 0) begin t = 0; a = a & ~32'h3; end
      end
      d = (a == BASE + 4) ? m_cycle + $urandom_range(1, 20) : $urandom;
      dbg_addr = 10'($urandom);
      step(1'($urandom), a, d, t, $urandom % 300 == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
